// File: rtl/int_issue_scheduler.sv
// Round-robin issue arbiter for the shared integer pipe: combinational one-hot grant, registered issue/status one cycle later.
// pipe_stall suppresses all grants; per-thread branch and credit limits gate eligibility. INT_ISSUE_PERF_EN adds perf block flags.
module int_issue_scheduler #(
    parameter int NUM_THREADS     = 4,
    parameter int MAX_OUTSTANDING = 3,
    parameter int TIDX_W          = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] ts_request,
    input  logic [NUM_THREADS-1:0] ts_request_branch,
    input  logic                   pipe_stall,
    output logic [NUM_THREADS-1:0] is_grant_oh,
    output logic                   is_issue_valid,
    output logic [TIDX_W-1:0]      is_issue_thread_idx,
    input  logic                   ix_retire_valid,
    input  logic [TIDX_W-1:0]      ix_retire_thread_idx,
    input  logic                   ix_retire_branch,
    input  logic                   wb_rollback_en,
    input  logic [TIDX_W-1:0]      wb_rollback_thread_idx,
    output logic [NUM_THREADS-1:0] is_thread_blocked,
`ifdef INT_ISSUE_PERF_EN
    output logic                   is_perf_branch_block,
    output logic                   is_perf_credit_block,
`endif
    output logic                   is_sched_error
);

    localparam logic [2:0]        MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [TIDX_W-1:0] LAST_RST = TIDX_W'(NUM_THREADS - 1);

    logic [2:0]             outstanding     [NUM_THREADS];
    logic [2:0]             outstanding_nxt [NUM_THREADS];
    logic [NUM_THREADS-1:0] branch_pending;
    logic [NUM_THREADS-1:0] branch_pending_nxt;
    logic [NUM_THREADS-1:0] blocked_nxt;
    logic [NUM_THREADS-1:0] rb_hit;
    logic [NUM_THREADS-1:0] ret_hit;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] grant_oh;
    logic [TIDX_W-1:0]      last_grant;
    logic [TIDX_W-1:0]      grant_idx;
    logic [TIDX_W-1:0]      cand_idx;
    logic                   grant_any;
    logic                   sched_error_set;

    // Eligibility looks only at current state, so the grant never depends on a retire.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            rb_hit[t]   = wb_rollback_en && (wb_rollback_thread_idx == TIDX_W'(t));
            ret_hit[t]  = ix_retire_valid && (ix_retire_thread_idx == TIDX_W'(t));
            eligible[t] = ts_request[t] && !branch_pending[t] &&
                          (outstanding[t] < MAX_CNT) && !rb_hit[t];
        end
    end

    always_comb begin
        grant_oh  = '0;
        grant_idx = last_grant;
        grant_any = 1'b0;
        cand_idx  = '0;
        if (!pipe_stall) begin
            for (int i = 1; i <= NUM_THREADS; i++) begin
                cand_idx = TIDX_W'((int'(last_grant) + i) % NUM_THREADS);
                if (!grant_any && eligible[cand_idx]) begin
                    grant_any          = 1'b1;
                    grant_idx          = cand_idx;
                    grant_oh[cand_idx] = 1'b1;
                end
            end
        end
    end

    assign is_grant_oh = grant_oh;

    // Rollback overrides grant and retire; a branch grant beats a same-cycle branch retire.
    always_comb begin
        outstanding_nxt    = outstanding;
        branch_pending_nxt = branch_pending;
        blocked_nxt        = '0;
        sched_error_set    = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (rb_hit[t]) begin
                outstanding_nxt[t]    = 3'd0;
                branch_pending_nxt[t] = 1'b0;
            end else begin
                if (grant_oh[t] && !ret_hit[t]) begin
                    outstanding_nxt[t] = outstanding[t] + 3'd1;
                end else if (ret_hit[t] && !grant_oh[t] && (outstanding[t] != 3'd0)) begin
                    outstanding_nxt[t] = outstanding[t] - 3'd1;
                end
                if (ret_hit[t] && (outstanding[t] == 3'd0)) begin
                    sched_error_set = 1'b1;
                end
                if (grant_oh[t] && ts_request_branch[t]) begin
                    branch_pending_nxt[t] = 1'b1;
                end else if (ret_hit[t] && ix_retire_branch) begin
                    branch_pending_nxt[t] = 1'b0;
                end
            end
            blocked_nxt[t] = branch_pending_nxt[t] || (outstanding_nxt[t] == MAX_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                outstanding[t] <= 3'd0;
            end
            branch_pending      <= '0;
            last_grant          <= LAST_RST;
            is_issue_valid      <= 1'b0;
            is_issue_thread_idx <= '0;
            is_thread_blocked   <= '0;
            is_sched_error      <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                outstanding[t] <= outstanding_nxt[t];
            end
            branch_pending    <= branch_pending_nxt;
            is_issue_valid    <= grant_any;
            is_thread_blocked <= blocked_nxt;
            if (grant_any) begin
                last_grant          <= grant_idx;
                is_issue_thread_idx <= grant_idx;
            end
            if (sched_error_set) begin
                is_sched_error <= 1'b1;
            end
        end
    end

`ifdef INT_ISSUE_PERF_EN
    logic [NUM_THREADS-1:0] at_limit;

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            at_limit[t] = (outstanding[t] == MAX_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_perf_branch_block <= 1'b0;
            is_perf_credit_block <= 1'b0;
        end else begin
            is_perf_branch_block <= |(ts_request & branch_pending);
            is_perf_credit_block <= |(ts_request & at_limit);
        end
    end
`endif

endmodule

// File: tb/tb_int_issue_scheduler.sv
// Scoreboarded bench for int_issue_scheduler: expected issue indices are queued at grant time and popped on is_issue_valid.
module tb_int_issue_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] ts_request;
    logic [3:0] ts_request_branch;
    logic       pipe_stall;
    logic [3:0] is_grant_oh;
    logic       is_issue_valid;
    logic [1:0] is_issue_thread_idx;
    logic       ix_retire_valid;
    logic [1:0] ix_retire_thread_idx;
    logic       ix_retire_branch;
    logic       wb_rollback_en;
    logic [1:0] wb_rollback_thread_idx;
    logic [3:0] is_thread_blocked;
    logic       is_sched_error;
`ifdef INT_ISSUE_PERF_EN
    logic       is_perf_branch_block;
    logic       is_perf_credit_block;
`endif

    int         checks;
    int         failures;
    logic [1:0] exp_q[$];
    logic [1:0] sb_exp;
    logic [3:0] exp_oh;

    int_issue_scheduler #(.NUM_THREADS(4), .MAX_OUTSTANDING(3), .TIDX_W(2)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ts_request             (ts_request),
        .ts_request_branch      (ts_request_branch),
        .pipe_stall             (pipe_stall),
        .is_grant_oh            (is_grant_oh),
        .is_issue_valid         (is_issue_valid),
        .is_issue_thread_idx    (is_issue_thread_idx),
        .ix_retire_valid        (ix_retire_valid),
        .ix_retire_thread_idx   (ix_retire_thread_idx),
        .ix_retire_branch       (ix_retire_branch),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .is_thread_blocked      (is_thread_blocked),
`ifdef INT_ISSUE_PERF_EN
        .is_perf_branch_block   (is_perf_branch_block),
        .is_perf_credit_block   (is_perf_credit_block),
`endif
        .is_sched_error         (is_sched_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!reset && is_issue_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_idx: got unexpected issue of thread %0d, required no issue", is_issue_thread_idx);
            end else begin
                sb_exp = exp_q.pop_front();
                if (is_issue_thread_idx !== sb_exp) begin
                    failures++;
                    $display("FAIL issue_idx: got %0d required %0d", is_issue_thread_idx, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ts_request             = '0;
        ts_request_branch      = '0;
        pipe_stall             = 1'b0;
        ix_retire_valid        = 1'b0;
        ix_retire_thread_idx   = '0;
        ix_retire_branch       = 1'b0;
        wb_rollback_en         = 1'b0;
        wb_rollback_thread_idx = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        #3;
        checks++;
        if (is_issue_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b required 0", is_issue_valid);
        end
        checks++;
        if (is_thread_blocked !== 4'b0000) begin
            failures++; $display("FAIL reset_blocked: got %b required 0000", is_thread_blocked);
        end
        checks++;
        if (is_sched_error !== 1'b0) begin
            failures++; $display("FAIL reset_error: got %b required 0", is_sched_error);
        end
        checks++;
        if (is_grant_oh !== 4'b0000) begin
            failures++; $display("FAIL reset_grant: got %b required 0000", is_grant_oh);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        ts_request = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            ix_retire_valid      = (i > 0);
            ix_retire_thread_idx = 2'((i + 3) % 4);
            #3;
            exp_oh = 4'b0001 << (i % 4);
            checks++;
            if (is_grant_oh !== exp_oh) begin
                failures++; $display("FAIL rr_grant[%0d]: got %b required %b", i, is_grant_oh, exp_oh);
            end
            exp_q.push_back(2'(i % 4));
            cyc();
        end
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd3;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0000) begin
            failures++; $display("FAIL rr_idle: got %b required 0000", is_grant_oh);
        end
        cyc();
        ix_retire_valid = 1'b0;
    endtask

    task automatic test_stall();
        ts_request = 4'b0010;
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (is_grant_oh !== 4'b0000) begin
                failures++; $display("FAIL stall_grant[%0d]: got %b required 0000", i, is_grant_oh);
            end
            checks++;
            if (is_issue_valid !== 1'b0) begin
                failures++; $display("FAIL stall_valid[%0d]: got %b required 0", i, is_issue_valid);
            end
            cyc();
        end
        pipe_stall = 1'b0;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0010) begin
            failures++; $display("FAIL stall_release: got %b required 0010", is_grant_oh);
        end
        exp_q.push_back(2'd1);
        cyc();
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd1;
        cyc();
        ix_retire_valid = 1'b0;
    endtask

    task automatic test_branch_block();
        ts_request        = 4'b0100;
        ts_request_branch = 4'b0100;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0100) begin
            failures++; $display("FAIL br_first: got %b required 0100", is_grant_oh);
        end
        exp_q.push_back(2'd2);
        cyc();
        ts_request_branch = '0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (is_grant_oh !== 4'b0000) begin
                failures++; $display("FAIL br_hold[%0d]: got %b required 0000", i, is_grant_oh);
            end
            checks++;
            if (is_thread_blocked[2] !== 1'b1) begin
                failures++; $display("FAIL br_blocked[%0d]: got %b required 1", i, is_thread_blocked[2]);
            end
            cyc();
        end
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd2;
        ix_retire_branch     = 1'b1;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0000) begin
            failures++; $display("FAIL br_resolve_cycle: got %b required 0000", is_grant_oh);
        end
        cyc();
        ix_retire_valid  = 1'b0;
        ix_retire_branch = 1'b0;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0100) begin
            failures++; $display("FAIL br_regrant: got %b required 0100", is_grant_oh);
        end
        checks++;
        if (is_thread_blocked[2] !== 1'b0) begin
            failures++; $display("FAIL br_unblocked: got %b required 0", is_thread_blocked[2]);
        end
        exp_q.push_back(2'd2);
        cyc();
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd2;
        cyc();
        ix_retire_valid = 1'b0;
    endtask

    task automatic test_credit_limit();
        ts_request = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #3;
            exp_oh = (i < 3) ? 4'b0001 : 4'b0000;
            checks++;
            if (is_grant_oh !== exp_oh) begin
                failures++; $display("FAIL credit_grant[%0d]: got %b required %b", i, is_grant_oh, exp_oh);
            end
            if (i < 3) exp_q.push_back(2'd0);
            if (i >= 3) begin
                checks++;
                if (is_thread_blocked[0] !== 1'b1) begin
                    failures++; $display("FAIL credit_blocked[%0d]: got %b required 1", i, is_thread_blocked[0]);
                end
            end
            cyc();
        end
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd0;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0000) begin
            failures++; $display("FAIL credit_retire_cycle: got %b required 0000", is_grant_oh);
        end
        cyc();
        ix_retire_valid = 1'b0;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0001) begin
            failures++; $display("FAIL credit_one_more: got %b required 0001", is_grant_oh);
        end
        checks++;
        if (is_thread_blocked[0] !== 1'b0) begin
            failures++; $display("FAIL credit_freed: got %b required 0", is_thread_blocked[0]);
        end
        exp_q.push_back(2'd0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++;
            if (is_grant_oh !== 4'b0000) begin
                failures++; $display("FAIL credit_reblock[%0d]: got %b required 0000", i, is_grant_oh);
            end
            cyc();
        end
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd0;
        repeat (3) cyc();
        ix_retire_valid = 1'b0;
    endtask

    task automatic test_rollback();
        ts_request = 4'b1000;
        #3;
        checks++;
        if (is_grant_oh !== 4'b1000) begin
            failures++; $display("FAIL rb_setup0: got %b required 1000", is_grant_oh);
        end
        exp_q.push_back(2'd3);
        cyc();
        ts_request_branch = 4'b1000;
        #3;
        checks++;
        if (is_grant_oh !== 4'b1000) begin
            failures++; $display("FAIL rb_setup1: got %b required 1000", is_grant_oh);
        end
        exp_q.push_back(2'd3);
        cyc();
        ts_request_branch      = '0;
        wb_rollback_en         = 1'b1;
        wb_rollback_thread_idx = 2'd3;
        ix_retire_valid        = 1'b1;
        ix_retire_thread_idx   = 2'd3;
        ix_retire_branch       = 1'b1;
        #3;
        checks++;
        if (is_thread_blocked[3] !== 1'b1) begin
            failures++; $display("FAIL rb_pending_before: got %b required 1", is_thread_blocked[3]);
        end
        checks++;
        if (is_grant_oh !== 4'b0000) begin
            failures++; $display("FAIL rb_no_grant: got %b required 0000", is_grant_oh);
        end
        cyc();
        wb_rollback_en   = 1'b0;
        ix_retire_valid  = 1'b0;
        ix_retire_branch = 1'b0;
        #3;
        checks++;
        if (is_grant_oh !== 4'b1000) begin
            failures++; $display("FAIL rb_regrant: got %b required 1000", is_grant_oh);
        end
        checks++;
        if (is_thread_blocked[3] !== 1'b0) begin
            failures++; $display("FAIL rb_cleared: got %b required 0", is_thread_blocked[3]);
        end
        checks++;
        if (is_sched_error !== 1'b0) begin
            failures++; $display("FAIL rb_error: got %b required 0", is_sched_error);
        end
        exp_q.push_back(2'd3);
        cyc();
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd3;
        #3;
        checks++;
        if (is_thread_blocked[3] !== 1'b0) begin
            failures++; $display("FAIL rb_count_one: got %b required 0", is_thread_blocked[3]);
        end
        cyc();
        ix_retire_valid = 1'b0;
        #3;
        checks++;
        if (is_sched_error !== 1'b0) begin
            failures++; $display("FAIL rb_error_after: got %b required 0", is_sched_error);
        end
        cyc();
    endtask

    task automatic test_underflow();
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd1;
        #3;
        checks++;
        if (is_sched_error !== 1'b0) begin
            failures++; $display("FAIL uf_before: got %b required 0", is_sched_error);
        end
        cyc();
        ix_retire_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            checks++;
            if (is_sched_error !== 1'b1) begin
                failures++; $display("FAIL uf_sticky[%0d]: got %b required 1", i, is_sched_error);
            end
            cyc();
        end
        ts_request        = 4'b0001;
        ts_request_branch = 4'b0001;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0001) begin
            failures++; $display("FAIL uf_pre_reset_grant: got %b required 0001", is_grant_oh);
        end
        exp_q.push_back(2'd0);
        cyc();
        ts_request        = '0;
        ts_request_branch = '0;
        #3;
        checks++;
        if (is_thread_blocked[0] !== 1'b1) begin
            failures++; $display("FAIL uf_pre_reset_blocked: got %b required 1", is_thread_blocked[0]);
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #3;
        checks++;
        if (is_sched_error !== 1'b0) begin
            failures++; $display("FAIL uf_reset_error: got %b required 0", is_sched_error);
        end
        checks++;
        if (is_thread_blocked !== 4'b0000) begin
            failures++; $display("FAIL uf_reset_blocked: got %b required 0000", is_thread_blocked);
        end
        cyc();
        ts_request = 4'b1111;
        #3;
        checks++;
        if (is_grant_oh !== 4'b0001) begin
            failures++; $display("FAIL uf_reset_pointer: got %b required 0001", is_grant_oh);
        end
        exp_q.push_back(2'd0);
        cyc();
        ts_request           = '0;
        ix_retire_valid      = 1'b1;
        ix_retire_thread_idx = 2'd0;
        cyc();
        ix_retire_valid = 1'b0;
        cyc();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_stall();
        test_branch_block();
        test_credit_limit();
        test_rollback();
        test_underflow();
        repeat (2) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_drain: got %0d pending issues required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
